// File: rtl/cr_field_arbiter.sv
// Round-robin arbiter for per-field condition-register writes.
// Also accepts whole-register loads, which take priority over field writes.
module cr_field_arbiter #(
  parameter int          NREQ     = 4,
  parameter logic [31:0] CR_RESET = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_sel,
  input  logic [4*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    hold,
  input  logic                    cr_load,
  input  logic [31:0]             cr_load_data,
  output logic                    cr_we,
  output logic [2:0]              cr_idx,
  output logic [3:0]              cr_wdata,
  output logic [31:0]             cr_q,
  output logic                    err_valid,
  output logic [$clog2(NREQ)-1:0] err_src
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic          gnt_ok;
  logic [7:0]    sel_g;
  logic [3:0]    dat_g;
  logic          legal;
  logic [2:0]    fld;
  logic [31:0]   cr_d;
  logic          we_q;
  logic [2:0]    idx_q;
  logic [3:0]    wdata_q;
  logic          err_q;
  logic [PW-1:0] src_q;
  int            j;

  // First valid requester at or above rr_q, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_q) + k) % NREQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

  assign gnt_ok    = gnt_any & rst_n & ~hold & ~cr_load;
  assign req_ready = gnt_ok ? (NREQ'(1) << gnt_idx) : '0;
  assign sel_g     = req_sel[{gnt_idx, 3'b000} +: 8];
  assign dat_g     = req_data[{gnt_idx, 2'b00} +: 4];
  assign legal     = $onehot(sel_g);

  always_comb begin
    fld = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (sel_g[b]) fld = 3'(b);
    end
  end

  // Field i sits at bits 31-4i:28-4i, i.e. base 4*(7-i).
  always_comb begin
    cr_d = cr_q;
    if (cr_load) begin
      cr_d = cr_load_data;
    end else if (gnt_ok && legal) begin
      cr_d[{~fld, 2'b00} +: 4] = dat_g;
    end
    rr_d = rr_q;
    if (gnt_ok) begin
      rr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cr_q    <= CR_RESET;
      rr_q    <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      src_q   <= '0;
    end else begin
      cr_q  <= cr_d;
      rr_q  <= rr_d;
      we_q  <= gnt_ok & legal;
      err_q <= gnt_ok & ~legal;
      if (gnt_ok && legal) begin
        idx_q   <= fld;
        wdata_q <= dat_g;
      end
      if (gnt_ok && !legal) begin
        src_q <= gnt_idx;
      end
    end
  end

  assign cr_we     = we_q;
  assign cr_idx    = idx_q;
  assign cr_wdata  = wdata_q;
  assign err_valid = err_q;
  assign err_src   = src_q;

endmodule
